// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder cell.
module full_adder (
    input  logic i_x,
    input  logic i_y,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_x ^ i_y ^ i_carry;
    assign o_carry = (i_x & i_y) | (i_carry & (i_x ^ i_y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: feeds one operand bit pair per clock to a full_adder, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_sr_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, busy_q, done_q;
    logic             fa_sum, fa_carry;
    logic [WIDTH-1:0] sum_sr_next;

    full_adder u_full_adder (
        .i_x     (a_q[0]),
        .i_y     (b_q[0]),
        .i_carry (carry_q),
        .o_sum   (fa_sum),
        .o_carry (fa_carry)
    );

    // New sum bit enters at the MSB; written without slicing so WIDTH = 1 works.
    assign sum_sr_next = (sum_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (i_start) begin
                        state_q  <= StRun;
                        a_q      <= i_a;
                        b_q      <= i_b;
                        carry_q  <= i_carry;
                        cnt_q    <= '0;
                        sum_sr_q <= '0;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                    sum_sr_q <= sum_sr_next;
                    carry_q  <= fa_carry;
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= sum_sr_next;
                        cout_q  <= fa_carry;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_sum   = sum_q;
    assign o_carry = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results, a monitor pops on o_done.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         i_carry = 1'b0;
    logic         o_busy, o_done, o_carry;
    logic [W-1:0] o_sum;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   pushed = 0;

    serial_adder #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_carry (i_carry),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sum   (o_sum),
        .o_carry (o_carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every o_done must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (o_busy && o_done) check("busy_and_done", 1, 0);
            if (o_done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sum", int'(o_sum), int'(e.sum));
                    check("carry", int'(o_carry), int'(e.carry));
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Issue a one-cycle start; returns at the negedge after the accepting edge.
    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W-1:0] es, input logic ec, input bit expect_done);
        @(negedge clk);
        i_a = a;
        i_b = b;
        i_carry = c;
        i_start = 1'b1;
        if (expect_done) begin
            q.push_back('{sum: es, carry: ec, cyc: cyc + 1 + W});
            pushed++;
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (!o_busy && !o_done && q.size() == 0) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    initial begin
        int d0;
        int k;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_sum", int'(o_sum), 0);
        check("rst_carry", int'(o_carry), 0);

        // Basic add with latency and busy-window checks
        go(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            check("busy_window", int'(o_busy), 1);
            check("no_early_done", int'(o_done), 0);
        end
        @(negedge clk);
        check("busy_at_done", int'(o_busy), 0);
        check("done_at_latency", int'(o_done), 1);
        wait_idle();

        go(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
        wait_idle();
        go(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);
        wait_idle();

        // Start while busy is ignored; operand changes after capture are ignored
        d0 = done_cnt;
        go(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        i_a = 8'hAA;
        i_b = 8'h55;
        i_carry = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_idle();
        check("single_done", done_cnt - d0, 1);
        check("held_sum", int'(o_sum), 8'h30);

        // Reset mid-run aborts with no done pulse
        d0 = done_cnt;
        go(8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("abort_busy", int'(o_busy), 0);
        check("abort_sum", int'(o_sum), 0);
        check("abort_carry", int'(o_carry), 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);

        // Reset wins over a simultaneous start
        @(negedge clk);
        i_rst = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        i_start = 1'b0;
        check("rst_over_start", int'(o_busy), 0);
        wait_idle();

        // Back-to-back with start held: DONE accepts the next operation
        @(negedge clk);
        i_a = 8'h01;
        i_b = 8'h01;
        i_carry = 1'b0;
        i_start = 1'b1;
        k = cyc + 1;
        q.push_back('{sum: 8'h02, carry: 1'b0, cyc: k + W});
        q.push_back('{sum: 8'h00, carry: 1'b1, cyc: k + 2 * W + 1});
        pushed += 2;
        @(negedge clk);
        i_a = 8'h80;
        i_b = 8'h80;
        repeat (W + 1) @(negedge clk);
        i_start = 1'b0;
        wait_idle();

        check("queue_drained", q.size(), 0);
        check("done_count", done_cnt, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
